// File: rtl/data_bridge_pkg.sv
// Shared constants and helpers for the CPU data-port bridge.
// Register offsets are byte offsets within the configuration window.
package data_bridge_pkg;

    localparam logic [31:0] CONF_BASE_DEFAULT = 32'h1FAF_0000;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_TIMER   = 16'h0008;
    localparam logic [15:0] OFF_COMPARE = 16'h000C;
    localparam logic [15:0] OFF_STATUS  = 16'h0010;
    localparam logic [15:0] OFF_SCRATCH = 16'h0014;

    // Replace the bytes of old_word whose enable bit is set with new_word's bytes.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  wen);
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (wen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_bridge_conf_regs.sv
// Configuration register window: LED, switch, free-running timer with
// compare/match flag, scratch, and a registered read mux (1-cycle latency).
module conf_regs
    import data_bridge_pkg::*;
#(
    parameter int unsigned LED_W = 16,
    parameter int unsigned SW_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hit,
    input  logic [3:0]        wen,
    input  logic [13:0]       word_off,
    input  logic [31:0]       wdata,
    input  logic [SW_W-1:0]   switch_in,
    output logic [LED_W-1:0]  led_out,
    output logic              timer_irq,
    output logic [31:0]       rdata
);

    logic [LED_W-1:0] led_q;
    logic [31:0]      timer_q;
    logic [31:0]      compare_q;
    logic [31:0]      scratch_q;
    logic             flag_q;
    logic [31:0]      rdata_q;

    logic             wr;
    logic             is_led, is_timer, is_compare, is_status, is_scratch;
    logic             flag_clr;
    logic [31:0]      led_ext;
    logic [31:0]      sw_ext;
    logic [31:0]      read_val;

    assign wr         = hit & (wen != 4'b0000);
    assign is_led     = (word_off == OFF_LED[15:2]);
    assign is_timer   = (word_off == OFF_TIMER[15:2]);
    assign is_compare = (word_off == OFF_COMPARE[15:2]);
    assign is_status  = (word_off == OFF_STATUS[15:2]);
    assign is_scratch = (word_off == OFF_SCRATCH[15:2]);
    assign flag_clr   = wr & is_status & wen[0] & wdata[0];

    // Zero-extend the narrow LED and switch fields to a 32-bit read word
    always_comb begin
        led_ext = '0;
        led_ext[LED_W-1:0] = led_q;
        sw_ext = '0;
        sw_ext[SW_W-1:0] = switch_in;
    end

    // Read mux over current register values; unmapped offsets read zero
    always_comb begin
        read_val = '0;
        case (word_off)
            OFF_LED[15:2]:     read_val = led_ext;
            OFF_SWITCH[15:2]:  read_val = sw_ext;
            OFF_TIMER[15:2]:   read_val = timer_q;
            OFF_COMPARE[15:2]: read_val = compare_q;
            OFF_STATUS[15:2]:  read_val = {31'b0, flag_q};
            OFF_SCRATCH[15:2]: read_val = scratch_q;
            default:           read_val = '0;
        endcase
    end

    // LED register with per-byte write enables
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
        end else if (wr && is_led) begin
            for (int unsigned i = 0; i < LED_W; i++) begin
                if (wen[i/8]) led_q[i] <= wdata[i];
            end
        end
    end

    // Free-running timer; a CPU write replaces that cycle's increment
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else if (wr && is_timer) begin
            timer_q <= byte_merge(timer_q, wdata, wen);
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    // Compare and scratch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            compare_q <= '1;
            scratch_q <= '0;
        end else begin
            if (wr && is_compare) compare_q <= byte_merge(compare_q, wdata, wen);
            if (wr && is_scratch) scratch_q <= byte_merge(scratch_q, wdata, wen);
        end
    end

    // Match flag: set on pre-update equality, set beats write-1-to-clear
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= (timer_q == compare_q) | (flag_q & ~flag_clr);
        end
    end

    // Capture read data in the request cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (hit) begin
            rdata_q <= read_val;
        end
    end

    assign led_out   = led_q;
    assign timer_irq = flag_q;
    assign rdata     = rdata_q;

endmodule

// File: rtl/data_bridge.sv
// CPU data-port bridge: routes each access to data_ram or the on-chip
// configuration window, presenting a uniform 1-cycle-latency slave.
// Optional macro DATA_BRIDGE_KSEG_XLAT_EN clears addr[31:29] for kseg0/kseg1
// addresses before decode and RAM routing.
module data_bridge
    import data_bridge_pkg::*;
#(
    parameter logic [31:0] CONF_BASE = CONF_BASE_DEFAULT,
    parameter int unsigned LED_W     = 16,
    parameter int unsigned SW_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_data_en,
    input  logic [3:0]        cpu_data_wen,
    input  logic [31:0]       cpu_data_addr,
    input  logic [31:0]       cpu_data_wdata,
    output logic [31:0]       cpu_data_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [31:0]       ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [SW_W-1:0]   switch_in,
    output logic [LED_W-1:0]  led_out,
    output logic              timer_irq
);

    logic [31:0] addr_x;
    logic        conf_hit;
    logic        ram_hit;
    logic        sel_q;
    logic [31:0] conf_rdata_q;

    // Address seen by decode and RAM (optionally kseg-translated)
    always_comb begin
        addr_x = cpu_data_addr;
`ifdef DATA_BRIDGE_KSEG_XLAT_EN
        if (cpu_data_addr[31:30] == 2'b10) addr_x[31:29] = 3'b000;
`endif
    end

    assign conf_hit = cpu_data_en & (addr_x[31:16] == CONF_BASE[31:16]);
    assign ram_hit  = cpu_data_en & ~conf_hit;

    assign ram_en    = ram_hit;
    assign ram_wen   = ram_hit ? cpu_data_wen : 4'b0000;
    assign ram_addr  = addr_x;
    assign ram_wdata = cpu_data_wdata;

    // Remember whether the previous cycle was a configuration read
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= conf_hit & (cpu_data_wen == 4'b0000);
        end
    end

    assign cpu_data_rdata = sel_q ? conf_rdata_q : ram_rdata;

    conf_regs #(
        .LED_W (LED_W),
        .SW_W  (SW_W)
    ) u_conf_regs (
        .clk       (clk),
        .rst       (rst),
        .hit       (conf_hit),
        .wen       (cpu_data_wen),
        .word_off  (addr_x[15:2]),
        .wdata     (cpu_data_wdata),
        .switch_in (switch_in),
        .led_out   (led_out),
        .timer_irq (timer_irq),
        .rdata     (conf_rdata_q)
    );

endmodule

// File: tb/tb_data_bridge.sv
// Self-checking bench for data_bridge with a behavioural data_ram and an
// expected-read-data scoreboard.
module tb_data_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_data_en = 1'b0;
    logic [3:0]  cpu_data_wen = 4'b0;
    logic [31:0] cpu_data_addr = '0;
    logic [31:0] cpu_data_wdata = '0;
    logic [31:0] cpu_data_rdata;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [7:0]  switch_in = 8'h00;
    logic [15:0] led_out;
    logic        timer_irq;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    typedef struct {
        bit          chk;
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    logic [31:0] mem [0:1023];

    data_bridge #(
        .CONF_BASE (32'h1FAF_0000),
        .LED_W     (16),
        .SW_W      (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_data_en    (cpu_data_en),
        .cpu_data_wen   (cpu_data_wen),
        .cpu_data_addr  (cpu_data_addr),
        .cpu_data_wdata (cpu_data_wdata),
        .cpu_data_rdata (cpu_data_rdata),
        .ram_en         (ram_en),
        .ram_wen        (ram_wen),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .switch_in      (switch_in),
        .led_out        (led_out),
        .timer_irq      (timer_irq)
    );

    always #5 clk = ~clk;

    // Behavioural data_ram: 1-cycle read latency, byte writes
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen == 4'b0000) begin
                ram_rdata <= mem[ram_addr[11:2]];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (ram_wen[i]) mem[ram_addr[11:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
                end
            end
        end
    end

    function automatic logic [31:0] xlat(input logic [31:0] a);
        logic [31:0] r;
        r = a;
`ifdef DATA_BRIDGE_KSEG_XLAT_EN
        if (a[31:30] == 2'b10) r[31:29] = 3'b000;
`endif
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle; RAM-side outputs checked combinationally, read data
    // checked one cycle later through the scoreboard.
    task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit chk, input logic [31:0] exp,
                         input string tag);
        sb_t  e;
        logic exp_ram_en;
        cpu_data_en    = en;
        cpu_data_wen   = wen;
        cpu_data_addr  = addr;
        cpu_data_wdata = wdata;
        e.chk = chk;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
        #1;
        exp_ram_en = en & (xlat(addr)[31:16] != 16'h1FAF);
        check_eq({tag, "_ram_en"}, {31'b0, ram_en}, {31'b0, exp_ram_en});
        check_eq({tag, "_ram_wen"}, {28'b0, ram_wen}, exp_ram_en ? {28'b0, wen} : 32'h0);
        if (exp_ram_en) check_eq({tag, "_ram_addr"}, ram_addr, xlat(addr));
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        if (e.chk) check_eq(e.tag, cpu_data_rdata, e.exp);
    endtask

    task automatic idle();
        drive(1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 32'h0, "idle");
    endtask

    localparam logic [31:0] A_LED     = 32'h1FAF_0000;
    localparam logic [31:0] A_SWITCH  = 32'h1FAF_0004;
    localparam logic [31:0] A_TIMER   = 32'h1FAF_0008;
    localparam logic [31:0] A_COMPARE = 32'h1FAF_000C;
    localparam logic [31:0] A_STATUS  = 32'h1FAF_0010;
    localparam logic [31:0] A_SCRATCH = 32'h1FAF_0014;

    initial begin
        logic [31:0] t1;
        logic [31:0] t2;
        int unsigned n;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        check_eq("rst_led", {16'b0, led_out}, 32'h0);
        check_eq("rst_irq", {31'b0, timer_irq}, 32'h0);
        check_eq("rst_rdata_ram", cpu_data_rdata, 32'h0);

        // Timer runs: two reads 5 cycles apart differ by 5
        drive(1'b1, 4'b0, A_TIMER, 32'h0, 1'b0, 32'h0, "timer_rd1");
        t1 = cpu_data_rdata;
        repeat (4) idle();
        drive(1'b1, 4'b0, A_TIMER, 32'h0, 1'b0, 32'h0, "timer_rd2");
        t2 = cpu_data_rdata;
        check_eq("timer_delta", t2 - t1, 32'd5);
        drive(1'b1, 4'b0, A_COMPARE, 32'h0, 1'b1, 32'hFFFF_FFFF, "compare_rst");
        check_eq("irq_idle", {31'b0, timer_irq}, 32'h0);

        // Byte-enabled LED writes
        drive(1'b1, 4'b0001, A_LED, 32'h0000_ABCD, 1'b0, 32'h0, "led_wr0");
        check_eq("led_b0", {16'b0, led_out}, 32'h0000_00CD);
        drive(1'b1, 4'b0010, A_LED, 32'h0000_1200, 1'b0, 32'h0, "led_wr1");
        check_eq("led_b1", {16'b0, led_out}, 32'h0000_12CD);
        drive(1'b1, 4'b0, A_LED, 32'h0, 1'b1, 32'h0000_12CD, "led_rd");

        // Timer/compare match
        drive(1'b1, 4'b1111, A_TIMER, 32'h0000_0010, 1'b0, 32'h0, "timer_wr");
        drive(1'b1, 4'b1111, A_COMPARE, 32'h0000_0014, 1'b0, 32'h0, "cmp_wr");
        n = 0;
        while (!timer_irq && n < 10) begin
            idle();
            n++;
        end
        check_eq("irq_latency", n, 32'd4);
        drive(1'b1, 4'b0, A_STATUS, 32'h0, 1'b1, 32'h0000_0001, "status_rd1");
        drive(1'b1, 4'b0001, A_STATUS, 32'h0000_0001, 1'b0, 32'h0, "w1c");
        check_eq("irq_cleared", {31'b0, timer_irq}, 32'h0);
        drive(1'b1, 4'b0, A_STATUS, 32'h0, 1'b1, 32'h0, "status_rd0");

        // W1C coinciding with the match cycle: set wins
        drive(1'b1, 4'b1111, A_TIMER, 32'h0000_0100, 1'b0, 32'h0, "timer_wr2");
        drive(1'b1, 4'b1111, A_COMPARE, 32'h0000_0103, 1'b0, 32'h0, "cmp_wr2");
        idle();
        idle();
        check_eq("irq_pre_match", {31'b0, timer_irq}, 32'h0);
        drive(1'b1, 4'b0001, A_STATUS, 32'h0000_0001, 1'b0, 32'h0, "w1c_match");
        check_eq("irq_set_wins", {31'b0, timer_irq}, 32'h1);
        drive(1'b1, 4'b0001, A_STATUS, 32'h0000_0001, 1'b0, 32'h0, "w1c_after");
        check_eq("irq_clr2", {31'b0, timer_irq}, 32'h0);

        // Back-to-back mixed RAM / conf traffic
        drive(1'b1, 4'b1111, A_SCRATCH, 32'h1234_5678, 1'b0, 32'h0, "scr_wr");
        drive(1'b1, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0, "ram_wr");
        drive(1'b1, 4'b0, A_SCRATCH, 32'h0, 1'b1, 32'h1234_5678, "scr_rd");
        drive(1'b1, 4'b0, 32'h0000_0100, 32'h0, 1'b1, 32'hDEAD_BEEF, "ram_rd");
        drive(1'b1, 4'b0, A_LED, 32'h0, 1'b1, 32'h0000_12CD, "led_rd2");

        // Switch, unmapped offset read/write
        switch_in = 8'hA5;
        drive(1'b1, 4'b0, A_SWITCH, 32'h0, 1'b1, 32'h0000_00A5, "switch_rd");
        drive(1'b1, 4'b0, 32'h1FAF_0100, 32'h0, 1'b1, 32'h0, "unmapped_rd");
        drive(1'b1, 4'b1111, 32'h1FAF_0100, 32'hFFFF_FFFF, 1'b0, 32'h0, "unmapped_wr");
        drive(1'b1, 4'b0, A_SCRATCH, 32'h0, 1'b1, 32'h1234_5678, "scr_keep");
        drive(1'b1, 4'b0, A_COMPARE, 32'h0, 1'b1, 32'h0000_0103, "cmp_keep");
        check_eq("led_keep", {16'b0, led_out}, 32'h0000_12CD);

`ifdef DATA_BRIDGE_KSEG_XLAT_EN
        drive(1'b1, 4'b0, 32'hBFAF_0014, 32'h0, 1'b1, 32'h1234_5678, "kseg_conf");
        drive(1'b1, 4'b0, 32'h8000_0100, 32'h0, 1'b1, 32'hDEAD_BEEF, "kseg_ram");
`else
        drive(1'b1, 4'b0, 32'hBFAF_0014, 32'h0, 1'b0, 32'h0, "phys_only");
        drive(1'b1, 4'b0, 32'h0000_0100, 32'h0, 1'b1, 32'hDEAD_BEEF, "ram_rd2");
`endif

        // Reset coinciding with a conf read: RAM data returned, registers reset
        rst = 1'b1;
        drive(1'b1, 4'b1111, A_LED, 32'h0000_5555, 1'b0, 32'h0, "rst_wr");
        drive(1'b1, 4'b0, A_SCRATCH, 32'h0, 1'b1, 32'hDEAD_BEEF, "rst_rd");
        rst = 1'b0;
        check_eq("rst2_led", {16'b0, led_out}, 32'h0);
        check_eq("rst2_irq", {31'b0, timer_irq}, 32'h0);
        drive(1'b1, 4'b0, A_SCRATCH, 32'h0, 1'b1, 32'h0, "rst2_scr");
        drive(1'b1, 4'b0, A_COMPARE, 32'h0, 1'b1, 32'hFFFF_FFFF, "rst2_cmp");
        drive(1'b1, 4'b0, A_LED, 32'h0, 1'b1, 32'h0, "rst2_led_rd");
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_bridge.md
Name: data_bridge

Overview:
- Sits between the CPU data SRAM port and data_ram at SoC top.
- Decodes each CPU data access to either data_ram or a small on-chip configuration register window: LEDs, switches, free-running timer with compare, and scratch.
- Returns read data with the same 1-cycle latency as data_ram, so the CPU sees one uniform synchronous-SRAM slave.

Parameters:
- CONF_BASE, 32'h1FAF_0000, base address of the register window; compared against addr[31:16].
- LED_W, 16, width of the LED output register.
- SW_W, 8, width of the switch input.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_data_en  in  1  access strobe.
- cpu_data_wen  in  4  byte write enables; 0 means read.
- cpu_data_addr  in  32  byte address.
- cpu_data_wdata  in  32  write data.
- cpu_data_rdata  out  32  read data, valid 1 cycle after the read request.
- ram_en  out  1  data_ram enable.
- ram_wen  out  4  data_ram byte enables.
- ram_addr  out  32  data_ram address.
- ram_wdata  out  32  data_ram write data.
- ram_rdata  in  32  data_ram read data (1-cycle latency).
- switch_in  in  SW_W  board switches; sampled, not synchronised here.
- led_out  out  LED_W  LED register value.
- timer_irq  out  1  compare-match flag.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Decode (combinational):
  - conf_hit = cpu_data_en & (addr[31:16] == CONF_BASE[31:16]).
  - ram_hit = cpu_data_en & ~conf_hit.
- RAM path (combinational):
  - ram_en = ram_hit.
  - ram_wen = ram_hit ? cpu_data_wen : 0.
  - ram_addr, ram_wdata pass through.
- Read select: registered sel_q <= {conf_hit & wen==0}.
  - sel_q=1: cpu_data_rdata = conf_rdata_q.
  - sel_q=0: cpu_data_rdata = ram_rdata.
- Register map, offset = addr[15:0], word aligned; addr[1:0] ignored.
  - 0x0000 LED: RW, bits [LED_W-1:0].
  - 0x0004 SWITCH: RO, zero-extended switch_in.
  - 0x0008 TIMER: RW; increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - 0x000C COMPARE: RW.
  - 0x0010 STATUS: bit0 = match flag; write-1-to-clear; other bits read 0.
  - 0x0014 SCRATCH: RW, 32 bits.
  - Any other offset inside the window: reads 0, writes ignored, no error.
- Writes:
  - Honour cpu_data_wen per byte on LED, TIMER, COMPARE and SCRATCH.
  - STATUS clear uses byte0 enable & wdata[0].
- conf_rdata_q: registered read mux of the current value, captured in the request cycle. Latency is exactly 1 cycle, matching the RAM.
- Timer priority: a CPU write to TIMER in a cycle replaces that cycle's increment. Written bytes load wdata; unwritten bytes keep the pre-increment value.
- Match:
  - Flag is set in any cycle where TIMER == COMPARE, compared on the register value before update.
  - Set and W1C in the same cycle: set wins.
  - timer_irq = flag.
- Reset values:
  - LED = 0, TIMER = 0, COMPARE = 32'hFFFF_FFFF, flag = 0, SCRATCH = 0.
  - sel_q = 0, conf_rdata_q = 0.
  - cpu_data_rdata follows ram_rdata after reset.
- Reset mid-operation: a read issued in the cycle rst is high returns RAM data next cycle (sel_q forced 0). Register writes in that cycle are dropped.
- Back-to-back accesses are supported every cycle with no stall. Mixed RAM/conf sequences select correctly per cycle.

Optional Feature:
- DATA_BRIDGE_KSEG_XLAT_EN defined: before decode, MIPS kseg0/kseg1 addresses (addr[31:30]==2'b10) have addr[31:29] cleared.
  - Both ram_addr and the conf compare use the translated address.
  - Example: 0xBFAF_0000 hits CONF; 0x8000_0100 -> ram_addr 0x0000_0100.
- Undefined: addresses pass through unmodified; only physical CONF_BASE hits the window.

Decomposition:
- Shared package data_bridge_pkg:
  - Offset constants: OFF_LED, OFF_SWITCH, OFF_TIMER, OFF_COMPARE, OFF_STATUS, OFF_SCRATCH.
  - Default CONF_BASE.
  - A byte-merge function (old, new, wen) -> merged word.
- One sub-module, conf_regs: register file, timer, match flag and registered read mux. data_bridge keeps decode, RAM routing, sel_q and the final mux.

Test Plan:
- Reset, then read 0x1FAF_0008 twice 5 cycles apart -> second value minus first = 5. COMPARE reads 0xFFFF_FFFF; timer_irq = 0.
- Write 0x0000_ABCD with wen=4'b0001 to LED, then wen=4'b0010 with 0x0000_1200 -> led_out = 16'h12CD. ram_en stays 0 throughout.
- Write TIMER = 0x0000_0010 and COMPARE = 0x0000_0014 -> timer_irq rises 4-5 cycles later. Write 1 to STATUS -> flag clears. A W1C issued in the exact match cycle leaves the flag at 1.
- Alternating every cycle: RAM write 0x100 = 0xDEAD_BEEF, conf read SCRATCH (preloaded 0x1234_5678), RAM read 0x100 -> rdata sequence ..., 0x1234_5678, 0xDEAD_BEEF with 1-cycle latency each.
- switch_in = 8'hA5, read 0x1FAF_0004 -> 0x0000_00A5. Read unmapped 0x1FAF_0100 -> 0. A write there changes no register and leaves ram_wen = 0.
- rst asserted in the same cycle as a conf read -> next-cycle rdata equals ram_rdata and all registers are at reset values. With DATA_BRIDGE_KSEG_XLAT_EN, a read of 0xBFAF_0014 returns SCRATCH.
